booth_rr_sequencer: RTL
=======================

BOOTH_RR_SEQUENCER -- requirements
Module: booth_rr_sequencer

Interface
REQ-001 Parameter N, default 8: operand width in bits, equal to the number of Booth iterations.
REQ-002 Parameter CW, default 4: iteration counter width; SHALL satisfy 2^CW > N.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-005 req0  input  1  requester 0 asks for the shared multiplier datapath; held high until done0.
REQ-006 req1  input  1  requester 1 asks for the shared multiplier datapath; held high until done1.
REQ-007 q0  input  1  LSB of datapath Q register.
REQ-008 qsub1  input  1  datapath Q(-1) bit.
REQ-009 sel  output  1  owner of the datapath operand muxes (0 = requester 0, 1 = requester 1).
REQ-010 CargaQ  output  1  load Q from the selected multiplier operand.
REQ-011 CargaM  output  1  load M from the selected multiplicand operand.
REQ-012 CargaA  output  1  load A with the adder/subtractor result.
REQ-013 Resta  output  1  adder/subtractor performs A-M (1) or A+M (0).
REQ-014 DesplazaAQ  output  1  arithmetic right shift of A:Q:Q(-1).
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done0  output  1  one-cycle pulse: requester 0 product valid in datapath.
REQ-017 done1  output  1  one-cycle pulse: requester 1 product valid in datapath.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, EVAL, SHIFT, DONE; register holds state, sel, last-served pointer, CW-bit iteration counter.
REQ-019 IDLE: no request -> IDLE; exactly one request -> LOAD with sel = that requester; both -> LOAD with sel = requester not last served.
REQ-020 Requests SHALL be sampled only in IDLE; sel SHALL stay constant from LOAD through DONE.
REQ-021 LOAD: CargaQ=CargaM=1, counter cleared to 0 (datapath clears A and Q(-1) on CargaQ); next state EVAL.
REQ-022 EVAL: CargaA = q0 XOR qsub1; Resta = q0 AND NOT qsub1; next state SHIFT.
REQ-023 Resta SHALL be 0 in every state other than EVAL.
REQ-024 SHIFT: DesplazaAQ=1, counter increments; next state EVAL if incremented counter < N, else DONE.
REQ-025 DONE: done0 (sel=0) or done1 (sel=1) high for exactly this one cycle; last-served pointer <= sel; next state IDLE.
REQ-026 Latency: LOAD entered on edge k -> DONE entered on edge k+2N+1 (k+17 for N=8); exactly N EVAL and N SHIFT cycles per operation.
REQ-027 Request deasserted mid-operation SHALL NOT abort; operation completes and done still pulses.
REQ-028 Requester holding req high after its done SHALL be re-arbitrated in IDLE; with both requesting, grants SHALL strictly alternate.
REQ-029 All control outputs SHALL be zero in IDLE and DONE except done0/done1 in DONE; at most one of CargaQ, CargaA, DesplazaAQ asserted per cycle.
REQ-030 Counter SHALL never wrap: maximum value reached is N.

Reset
REQ-031 reset SHALL asynchronously force state IDLE, counter 0, sel 0, last-served pointer 1 (requester 0 wins first tie), all outputs 0.
REQ-032 reset asserted mid-operation SHALL abort without any done pulse; first edge after release evaluates requests in IDLE.

Verification
REQ-033 N=8, req0 only, q0=1/qsub1=0 in every EVAL -> sel=0, 8 cycles CargaA=1 with Resta=1, 8 DesplazaAQ pulses, done0 on edge k+17, done1 never.
REQ-034 req0 and req1 rise together after reset -> grant sel=0, done0; next IDLE grants sel=1, done1; then sel=0 again.
REQ-035 req1 only, q0=qsub1=0 every EVAL -> CargaA and Resta never asserted, 8 DesplazaAQ pulses, single done1 pulse.
REQ-036 reset pulsed during 3rd SHIFT -> outputs 0 immediately, no done pulse, busy=0; held req0 regranted with full 2N+2-cycle sequence.
REQ-037 req0 dropped one cycle after LOAD -> sequence completes, done0 pulses once, FSM returns IDLE and stays IDLE.

Source files
------------

// File: rtl/booth_rr_sequencer_if.sv
// Handshake and datapath-control bundle between two requesters, the shared
// Booth multiplier datapath and the booth_rr_sequencer controller.
//   req0/req1   : per-requester service requests (held until the matching done)
//   q0/qsub1    : datapath Q[0] and Q(-1) status bits
//   sel         : operand mux owner (0 = requester 0, 1 = requester 1)
//   CargaQ/CargaM/CargaA/Resta/DesplazaAQ : datapath strobes
//   busy        : controller not idle
//   done0/done1 : one-cycle product-valid pulses
// The slave modport is the controller's view; master is the environment's.
interface booth_rr_sequencer_if;
  logic req0;
  logic req1;
  logic q0;
  logic qsub1;
  logic sel;
  logic CargaQ;
  logic CargaM;
  logic CargaA;
  logic Resta;
  logic DesplazaAQ;
  logic busy;
  logic done0;
  logic done1;

  modport master (
    output req0, req1, q0, qsub1,
    input  sel, CargaQ, CargaM, CargaA, Resta, DesplazaAQ, busy, done0, done1
  );

  modport slave (
    input  req0, req1, q0, qsub1,
    output sel, CargaQ, CargaM, CargaA, Resta, DesplazaAQ, busy, done0, done1
  );
endinterface

// File: rtl/booth_rr_sequencer.sv
// Booth radix-2 multiplier control sequencer shared by two requesters with
// round-robin arbitration on ties.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : booth_rr_sequencer_if.slave (requests, datapath status, strobes)
// Parameters:
//   N  : operand width = number of Booth iterations
//   CW : iteration counter width, must satisfy 2**CW > N
// Each operation runs LOAD, then N x (EVAL, SHIFT), then DONE, then IDLE.
module booth_rr_sequencer #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input logic clk,
  input logic reset,
  booth_rr_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic            sel_r, sel_n;
  logic            last_r, last_n;   // requester served most recently
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   cnt_inc;

  logic cq, cm, ca, rs, sh, d0, d1;

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sel_r  <= 1'b0;
      last_r <= 1'b1;               // requester 0 wins the first tie
      cnt    <= '0;
    end else begin
      state  <= state_n;
      sel_r  <= sel_n;
      last_r <= last_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_r;
    last_n  = last_r;
    cnt_n   = cnt;
    cq = 1'b0;
    cm = 1'b0;
    ca = 1'b0;
    rs = 1'b0;
    sh = 1'b0;
    d0 = 1'b0;
    d1 = 1'b0;
    case (state)
      IDLE: begin
        // Requests are only looked at here; sel is frozen until DONE.
        if (bus.req0 && bus.req1) begin
          sel_n   = ~last_r;
          state_n = LOAD;
        end else if (bus.req0) begin
          sel_n   = 1'b0;
          state_n = LOAD;
        end else if (bus.req1) begin
          sel_n   = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        cq      = 1'b1;
        cm      = 1'b1;
        cnt_n   = '0;
        state_n = EVAL;
      end
      EVAL: begin
        // 10 -> A-M, 01 -> A+M, 00/11 -> no add.
        ca      = bus.q0 ^ bus.qsub1;
        rs      = bus.q0 & ~bus.qsub1;
        state_n = SHIFT;
      end
      SHIFT: begin
        sh      = 1'b1;
        cnt_n   = cnt_inc;
        state_n = (cnt_inc < CW'(N)) ? EVAL : DONE;
      end
      DONE: begin
        d0      = ~sel_r;
        d1      = sel_r;
        last_n  = sel_r;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.sel        = sel_r;
  assign bus.CargaQ     = cq;
  assign bus.CargaM     = cm;
  assign bus.CargaA     = ca;
  assign bus.Resta      = rs;
  assign bus.DesplazaAQ = sh;
  assign bus.busy       = (state != IDLE);
  assign bus.done0      = d0;
  assign bus.done1      = d1;

endmodule
